// File: rtl/flash_mp_region_cfg_wr.sv
// Sequential writer for the flash memory-protection data-region table.
// It validates each request, waits out flash activity, then commits atomically with an optional sticky lock.
package flash_mp_region_cfg_wr_pkg;
  localparam int unsigned PkgAllPagesW = 9;
  localparam int unsigned PkgPermW     = 6;

  typedef enum logic [1:0] {
    PhaseSeed    = 2'd0,
    PhaseRma     = 2'd1,
    PhaseNone    = 2'd2,
    PhaseInvalid = 2'd3
  } flash_lcmgr_phase_e;

  // perm is ordered {he, ecc, scramble, erase, prog, rd}
  typedef struct packed {
    logic                      en;
    logic [PkgPermW-1:0]       perm;
    flash_lcmgr_phase_e        phase;
    logic [PkgAllPagesW-1:0]   base;
    logic [PkgAllPagesW:0]     size;
  } data_region_attr_t;
endpackage

module flash_mp_region_cfg_wr
  import flash_mp_region_cfg_wr_pkg::*;
#(
  parameter int unsigned Regions   = 4,
  // AllPagesW and PermW must match the widths used by data_region_attr_t
  parameter int unsigned AllPagesW = PkgAllPagesW,
  parameter int unsigned PermW     = PkgPermW,
  localparam int unsigned IdxW     = (Regions > 1) ? $clog2(Regions) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_req_i,
  input  logic [IdxW-1:0]       wr_idx_i,
  input  logic [AllPagesW-1:0]  wr_base_i,
  input  logic [AllPagesW:0]    wr_size_i,
  input  logic                  wr_en_i,
  input  logic [PermW-1:0]      wr_perm_i,
  input  flash_lcmgr_phase_e    wr_phase_i,
  input  logic                  wr_lock_i,
  input  logic                  flash_busy_i,
  output logic                  wr_ack_o,
  output logic                  wr_err_o,
  output logic [1:0]            wr_err_code_o,
  output logic                  busy_o,
  output logic [Regions-1:0]    locked_o,
  output data_region_attr_t     region_attrs_o [Regions]
);

  localparam int unsigned EndW = AllPagesW + 2;
  localparam logic [IdxW:0] RegionsW = (IdxW + 1)'(Regions);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT, COMMIT, ACK} state_e;

  state_e            state_reg, state_next;
  logic [IdxW-1:0]   hold_idx_reg;
  data_region_attr_t hold_attr_reg;
  logic              hold_lock_reg;
  data_region_attr_t attr_reg [Regions];
  logic [Regions-1:0] locked_reg;
  logic [Regions-1:0] wr_sel;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;
  logic [1:0]        code_reg, code_next;
  logic              busy_reg, busy_next;

  logic              lock_hit;
  logic [EndW-1:0]   chk_end;
  logic              chk_err;
  logic [1:0]        chk_code;

  // Validation of the latched request, in strict priority order
  always_comb begin
    lock_hit = 1'b0;
    for (int i = 0; i < Regions; i++) begin
      if (hold_idx_reg == IdxW'(i)) lock_hit = lock_hit | locked_reg[i];
    end
    chk_end  = EndW'(hold_attr_reg.base) + EndW'(hold_attr_reg.size);
    chk_err  = 1'b1;
    chk_code = 2'd0;
    if ({1'b0, hold_idx_reg} >= RegionsW)              chk_code = 2'd0;
    else if (lock_hit)                                 chk_code = 2'd1;
    else if (chk_end > (EndW'(1) << AllPagesW))        chk_code = 2'd2;
    else if (hold_attr_reg.en && hold_attr_reg.size == '0) chk_code = 2'd3;
    else                                               chk_err  = 1'b0;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (wr_req_i) state_next = CHECK;
      CHECK:   if (chk_err) state_next = ACK;
               else if (flash_busy_i) state_next = WAIT;
               else state_next = COMMIT;
      WAIT:    if (!flash_busy_i) state_next = COMMIT;
      COMMIT:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered
  always_comb begin
    ack_next  = (state_next == ACK);
    err_next  = (state_next == ACK) && (state_reg == CHECK);
    code_next = code_reg;
    if (state_next == ACK && state_reg == CHECK) code_next = chk_code;
    busy_next = (state_next != IDLE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < Regions; gi++) begin : g_sel
      assign wr_sel[gi] = (state_reg == COMMIT) && (hold_idx_reg == IdxW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      hold_idx_reg  <= '0;
      hold_attr_reg <= '0;
      hold_lock_reg <= 1'b0;
      locked_reg    <= '0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      code_reg      <= 2'd0;
      busy_reg      <= 1'b0;
      for (int i = 0; i < Regions; i++) attr_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      code_reg  <= code_next;
      busy_reg  <= busy_next;
      if (state_reg == IDLE && wr_req_i) begin
        hold_idx_reg  <= wr_idx_i;
        hold_lock_reg <= wr_lock_i;
        hold_attr_reg <= '{en: wr_en_i, perm: wr_perm_i, phase: wr_phase_i,
                           base: wr_base_i, size: wr_size_i};
      end
      for (int i = 0; i < Regions; i++) begin
        if (wr_sel[i]) begin
          attr_reg[i] <= hold_attr_reg;
          if (hold_lock_reg) locked_reg[i] <= 1'b1;
        end
      end
    end
  end

  assign wr_ack_o       = ack_reg;
  assign wr_err_o       = err_reg;
  assign wr_err_code_o  = code_reg;
  assign busy_o         = busy_reg;
  assign locked_o       = locked_reg;
  assign region_attrs_o = attr_reg;

endmodule

// File: tb/tb_flash_mp_region_cfg_wr.sv
// Scoreboard bench for flash_mp_region_cfg_wr: a 4-region and a 3-region instance share the write fields.
module tb_flash_mp_region_cfg_wr;
  import flash_mp_region_cfg_wr_pkg::*;

  typedef struct {
    logic       err;
    logic [1:0] code;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req4 = 1'b0, req3 = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [8:0] wr_base = '0;
  logic [9:0] wr_size = '0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_perm = '0;
  flash_lcmgr_phase_e wr_phase = PhaseNone;
  logic       wr_lock = 1'b0;
  logic       flash_busy = 1'b0;

  logic ack4, err4, busy4, ack3, err3, busy3;
  logic [1:0] code4, code3;
  logic [3:0] locked4;
  logic [2:0] locked3;
  data_region_attr_t attrs4 [4];
  data_region_attr_t attrs3 [3];

  exp_t q4[$], q3[$];
  int   cyc = 0, req_cyc4 = 0, req_cyc3 = 0;
  int   n_pass = 0, n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flash_mp_region_cfg_wr #(.Regions(4)) dut (
    .clk_i(clk), .rst_i(rst), .wr_req_i(req4), .wr_idx_i(wr_idx), .wr_base_i(wr_base),
    .wr_size_i(wr_size), .wr_en_i(wr_en), .wr_perm_i(wr_perm), .wr_phase_i(wr_phase),
    .wr_lock_i(wr_lock), .flash_busy_i(flash_busy), .wr_ack_o(ack4), .wr_err_o(err4),
    .wr_err_code_o(code4), .busy_o(busy4), .locked_o(locked4), .region_attrs_o(attrs4)
  );

  flash_mp_region_cfg_wr #(.Regions(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .wr_req_i(req3), .wr_idx_i(wr_idx), .wr_base_i(wr_base),
    .wr_size_i(wr_size), .wr_en_i(wr_en), .wr_perm_i(wr_perm), .wr_phase_i(wr_phase),
    .wr_lock_i(wr_lock), .flash_busy_i(flash_busy), .wr_ack_o(ack3), .wr_err_o(err3),
    .wr_err_code_o(code3), .busy_o(busy3), .locked_o(locked3), .region_attrs_o(attrs3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_ack(input string tag, input exp_t e, input int lat,
                           input logic err, input logic [1:0] code);
    $display("ack %s err=%0d code=%0d lat=%0d", tag, err, code, lat);
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    if (e.err) chk({tag, "_code"}, 32'(code), 32'(e.code));
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
  endtask

  // Monitors: every ack pops one expected response
  always @(negedge clk) begin
    if (ack4) begin
      if (q4.size() == 0) chk("unexpected_ack4", 32'd1, 32'd0);
      else check_ack("dut4", q4.pop_front(), cyc - req_cyc4, err4, code4);
    end
    if (ack3) begin
      if (q3.size() == 0) chk("unexpected_ack3", 32'd1, 32'd0);
      else check_ack("dut3", q3.pop_front(), cyc - req_cyc3, err3, code3);
    end
  end

  task automatic issue(input int which, input logic [1:0] idx, input logic [8:0] base,
                       input logic [9:0] size, input logic en, input logic [5:0] perm,
                       input logic lock, input logic e_err, input logic [1:0] e_code,
                       input int e_lat);
    exp_t e;
    int   k;
    logic got;
    @(negedge clk);
    e.err = e_err; e.code = e_code; e.lat = e_lat;
    wr_idx = idx; wr_base = base; wr_size = size; wr_en = en; wr_perm = perm; wr_lock = lock;
    if (which == 3) begin q3.push_back(e); req_cyc3 = cyc; req3 = 1'b1; end
    else begin q4.push_back(e); req_cyc4 = cyc; req4 = 1'b1; end
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      got = (which == 3) ? ack3 : ack4;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    req4 = 1'b0;
    req3 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(ack4), 32'd0);
    chk("rst_err", 32'(err4), 32'd0);
    chk("rst_code", 32'(code4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_locked", 32'(locked4), 32'd0);
    for (int i = 0; i < 4; i++) chk("rst_attr", 32'(attrs4[i]), 32'd0);

    // Clean write to region 1
    issue(4, 2'd1, 9'h010, 10'h020, 1'b1, 6'h03, 1'b0, 1'b0, 2'd0, 3);
    chk("r1_base", 32'(attrs4[1].base), 32'h010);
    chk("r1_size", 32'(attrs4[1].size), 32'h020);
    chk("r1_en", 32'(attrs4[1].en), 32'd1);
    chk("r1_perm", 32'(attrs4[1].perm), 32'h03);
    chk("r0_zero", 32'(attrs4[0]), 32'd0);
    chk("r2_zero", 32'(attrs4[2]), 32'd0);
    chk("r3_zero", 32'(attrs4[3]), 32'd0);

    // Overflow rejected; exact-end boundaries accepted
    issue(4, 2'd1, 9'h1F0, 10'h011, 1'b1, 6'h01, 1'b0, 1'b1, 2'd2, 2);
    chk("ovf_keep_base", 32'(attrs4[1].base), 32'h010);
    issue(4, 2'd3, 9'h1FF, 10'h001, 1'b1, 6'h01, 1'b0, 1'b0, 2'd0, 3);
    chk("r3_base", 32'(attrs4[3].base), 32'h1FF);
    issue(4, 2'd0, 9'h000, 10'h200, 1'b1, 6'h3F, 1'b0, 1'b0, 2'd0, 3);
    chk("r0_size", 32'(attrs4[0].size), 32'h200);

    // Lock region 2, then try to rewrite it
    issue(4, 2'd2, 9'h040, 10'h010, 1'b1, 6'h07, 1'b1, 1'b0, 2'd0, 3);
    chk("locked", 32'(locked4), 32'b0100);
    issue(4, 2'd2, 9'h080, 10'h008, 1'b1, 6'h01, 1'b0, 1'b1, 2'd1, 2);
    chk("lock_keep_base", 32'(attrs4[2].base), 32'h040);
    issue(4, 2'd2, 9'h1F0, 10'h020, 1'b1, 6'h01, 1'b0, 1'b1, 2'd1, 2);

    // Priority and index checks
    issue(3, 2'd3, 9'h000, 10'h000, 1'b1, 6'h01, 1'b0, 1'b1, 2'd0, 2);
    issue(4, 2'd1, 9'h020, 10'h000, 1'b1, 6'h01, 1'b0, 1'b1, 2'd3, 2);
    issue(4, 2'd1, 9'h020, 10'h000, 1'b0, 6'h01, 1'b0, 1'b0, 2'd0, 3);
    chk("r1_disabled", 32'(attrs4[1].en), 32'd0);

    // Busy interlock: flash busy in cycles 0..5 of the request
    fork
      issue(4, 2'd0, 9'h100, 10'h010, 1'b1, 6'h01, 1'b0, 1'b0, 2'd0, 8);
      begin
        @(negedge clk);
        flash_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (i <= 5) begin
            chk("wait_busy_o", 32'(busy4), 32'd1);
            chk("wait_no_commit", 32'(attrs4[0].base), 32'h000);
          end
        end
        flash_busy = 1'b0;
      end
    join
    chk("busy_commit", 32'(attrs4[0].base), 32'h100);

    // Reset while waiting: no ack, everything cleared
    @(negedge clk);
    wr_idx = 2'd1; wr_base = 9'h030; wr_size = 10'h004; wr_en = 1'b1; wr_lock = 1'b0;
    req4 = 1'b1;
    flash_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req4 = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_locked", 32'(locked4), 32'd0);
    chk("midrst_r0", 32'(attrs4[0]), 32'd0);
    chk("midrst_r2", 32'(attrs4[2]), 32'd0);
    rst = 1'b0;
    flash_busy = 1'b0;
    repeat (4) @(negedge clk);

    // Region 2 is writable again after reset
    issue(4, 2'd2, 9'h055, 10'h001, 1'b1, 6'h01, 1'b0, 1'b0, 2'd0, 3);
    chk("unlock_base", 32'(attrs4[2].base), 32'h055);

    repeat (3) @(negedge clk);
    chk("queue4_empty", 32'(q4.size()), 32'd0);
    chk("queue3_empty", 32'(q3.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
